// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the unified memory arbiter.
// The master modport is the pipeline/memory side; slave is the arbiter.
interface unified_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_valid;
   logic                  if_stall;
   logic                  flush_if;

   logic                  dm_req;
   logic                  dm_we;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [DATA_WIDTH-1:0] dm_rdata;
   logic                  dm_done;
   logic                  dm_stall;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  busy;

   modport master (
      output if_req, if_addr, flush_if,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_rdata, if_valid, if_stall,
      input  dm_rdata, dm_done, dm_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );

   modport slave (
      input  if_req, if_addr, flush_if,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_rdata, if_valid, if_stall,
      output dm_rdata, dm_done, dm_stall,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data memory.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise DM has fixed priority.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MEM_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   unified_mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_DM} state_t;

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

   state_t     r_state;
   logic [2:0] r_lat_cnt;
   logic       r_cancel;

   state_t     w_state_next;
   logic [2:0] w_lat_next;
   logic       w_cancel_next;

   logic       w_idle;
   logic       w_if_ok;
   logic       w_grant_dm;
   logic       w_grant_if;
   logic       w_done_cycle;

   assign w_idle       = (r_state == S_IDLE) && !rst;
   assign w_if_ok      = bus.if_req && !bus.flush_if;
   assign w_done_cycle = (r_state != S_IDLE) && (r_lat_cnt == 3'd0) && !rst;

`ifdef ARB_ROUND_ROBIN_EN
   localparam logic LAST_IF = 1'b0;
   localparam logic LAST_DM = 1'b1;

   logic r_last_grant;
   logic w_last_next;

   // On contention the port that lost last time wins; a lone requester always wins.
   assign w_grant_dm = w_idle && bus.dm_req && (!w_if_ok || (r_last_grant == LAST_IF));
   assign w_grant_if = w_idle && w_if_ok && !w_grant_dm;
   assign w_last_next = w_grant_dm ? LAST_DM : (w_grant_if ? LAST_IF : r_last_grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= LAST_DM;
      end else begin
         r_last_grant <= w_last_next;
      end
   end
`else
   assign w_grant_dm = w_idle && bus.dm_req;
   assign w_grant_if = w_idle && w_if_ok && !bus.dm_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_lat_cnt <= 3'd0;
         r_cancel  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_lat_cnt <= w_lat_next;
         r_cancel  <= w_cancel_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_lat_next    = r_lat_cnt;
      w_cancel_next = r_cancel;
      case (r_state)
         S_IDLE: begin
            w_cancel_next = 1'b0;
            if (w_grant_dm) begin
               w_state_next = S_BUSY_DM;
               w_lat_next   = LAT_INIT;
            end else if (w_grant_if) begin
               w_state_next = S_BUSY_IF;
               w_lat_next   = LAT_INIT;
            end
         end
         S_BUSY_IF, S_BUSY_DM: begin
            if (r_lat_cnt != 3'd0) begin
               w_lat_next = r_lat_cnt - 3'd1;
               // The access itself cannot be recalled; only its result is dropped.
               if ((r_state == S_BUSY_IF) && bus.flush_if) begin
                  w_cancel_next = 1'b1;
               end
            end else begin
               w_state_next  = S_IDLE;
               w_cancel_next = 1'b0;
            end
         end
         default: begin
            w_state_next  = S_IDLE;
            w_lat_next    = 3'd0;
            w_cancel_next = 1'b0;
         end
      endcase
   end

   always_comb begin
      bus.mem_en    = w_grant_dm || w_grant_if;
      bus.mem_we    = w_grant_dm && bus.dm_we;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (w_grant_dm) begin
         bus.mem_addr  = bus.dm_addr;
         bus.mem_wdata = bus.dm_wdata;
      end else if (w_grant_if) begin
         bus.mem_addr  = bus.if_addr;
      end

      bus.if_valid = w_done_cycle && (r_state == S_BUSY_IF) && !r_cancel && !bus.flush_if;
      bus.dm_done  = w_done_cycle && (r_state == S_BUSY_DM);
      bus.if_rdata = bus.if_valid ? bus.mem_rdata : '0;
      bus.dm_rdata = bus.dm_done  ? bus.mem_rdata : '0;

      bus.if_stall = bus.if_req && !bus.if_valid && !bus.flush_if;
      bus.dm_stall = bus.dm_req && !bus.dm_done;
      bus.busy     = ((r_state != S_IDLE) && !rst) || w_grant_dm || w_grant_if;
   end
endmodule
